iic_cfg_seq: RTL and testbench

Table-driven I2C register sequencer; the parametrised successor to the fixed single-device clock-generator init path. Walks a register table of up to `ENTRIES` entries, selects the I2C mux channel per entry, issues writes through the `simple_iic` wr/rd request interface, optionally reads back and verifies, and retries on NACK or mismatch. Sits between the board-level top and `simple_iic`, and can program several devices behind the TWI mux in one pass.

---
 rtl/iic_seq_pkg.sv | 33 +++
 rtl/iic_seq_retry.sv | 31 +++
 rtl/iic_cfg_seq.sv | 205 ++++++++++++++++++++
 tb/tb_iic_cfg_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_seq_pkg.sv
// Shared types for the table-driven I2C register sequencer.
// The entry body layout here is the low part of every table word; the mux channel sits above it.
package iic_seq_pkg;

  typedef struct packed {
    logic       last;
    logic       verify;
    logic [7:0] addr;
    logic [7:0] val;
  } seq_entry_t;

  localparam int unsigned SEQ_BODY_W = $bits(seq_entry_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUX,
    S_WRITE,
    S_READ,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  function automatic int unsigned ENTRY_W(input int unsigned ch_w);
    return ch_w + SEQ_BODY_W;
  endfunction

endpackage

// File: rtl/iic_seq_retry.sv
// Per-entry retry counter: decides between another attempt and giving up on an error.
module iic_seq_retry
#(
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_err,
  input  logic i_clr,
  output logic o_retry,
  output logic o_give_up
);

  logic [3:0] r_cnt;

  always_comb begin
    o_retry   = 1'b0;
    o_give_up = 1'b0;
    if (i_err) begin
      if (r_cnt < 4'(MAX_RETRY)) o_retry = 1'b1;
      else                       o_give_up = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (o_retry) r_cnt <= r_cnt + 4'd1;
  end

endmodule

// File: rtl/iic_cfg_seq.sv
// Table-driven I2C register sequencer in front of simple_iic, with per-entry mux channel select.
// Optional read-back verification is built in when IIC_SEQ_VERIFY_EN is defined.
module iic_cfg_seq
  import iic_seq_pkg::*;
#(
  parameter  int ENTRIES    = 64,
  parameter  int CHANNELS   = 4,
  parameter  int MAX_RETRY  = 3,
  parameter  int MUX_SETTLE = 16,
  localparam int IDX_W      = $clog2(ENTRIES),
  localparam int CH_W       = ch_width(CHANNELS),
  localparam int EW         = ENTRY_W(CH_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [EW-1:0]    tbl_entry,
  output logic [CH_W-1:0]  twi_mux,
  output logic             wr_req,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  input  logic             wr_fin,
  input  logic             wr_ack,
  output logic             rd_req,
  output logic [7:0]       rd_addr,
  input  logic [7:0]       rd_data,
  input  logic             rd_fin,
  input  logic             rd_ack,
  output logic             busy,
  output logic             init_done,
  output logic             init_fail,
  output logic [IDX_W-1:0] fail_idx
);

  localparam int SET_W = $clog2(MUX_SETTLE + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CH_W-1:0] w_ch;
  seq_entry_t      w_body;
  logic            r_auto;
  logic            r_first;
  logic            r_last;
  logic [SET_W-1:0] r_settle;
  logic            w_err;
  logic            w_clr;
  logic            w_retry;
  logic            w_give_up;
  logic            w_wr_ok;
  logic            w_rd_ok;

  assign w_ch   = tbl_entry[EW-1 -: CH_W];
  assign w_body = tbl_entry[SEQ_BODY_W-1:0];
  assign busy   = !(r_state inside {S_IDLE, S_DONE, S_FAIL});

  assign w_wr_ok = (r_state == S_WRITE) && wr_req && wr_fin && wr_ack;

`ifdef IIC_SEQ_VERIFY_EN
  logic r_verify;

  assign w_rd_ok = (r_state == S_READ) && rd_req && rd_fin && rd_ack && (rd_data == wr_data);
`else
  logic w_unused;

  assign w_rd_ok  = 1'b0;
  assign rd_req   = 1'b0;
  assign rd_addr  = 8'h00;
  assign w_unused = ^{w_body.verify, rd_data, rd_fin, rd_ack};
`endif

  // A fin only counts while the matching request is actually outstanding.
  always_comb begin
    w_err = 1'b0;
    if (r_state == S_WRITE && wr_req && wr_fin && !wr_ack) w_err = 1'b1;
`ifdef IIC_SEQ_VERIFY_EN
    if (r_state == S_READ && rd_req && rd_fin && (!rd_ack || rd_data != wr_data)) w_err = 1'b1;
`endif
  end

  iic_seq_retry #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_err     (w_err),
    .i_clr     (w_clr),
    .o_retry   (w_retry),
    .o_give_up (w_give_up)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start || r_auto) begin
          w_next = S_FETCH;
          w_clr  = 1'b1;
        end
      end
      S_FETCH: w_next = (r_first || w_ch != twi_mux) ? S_MUX : S_WRITE;
      S_MUX: begin
        if (r_settle == SET_W'(MUX_SETTLE - 1)) w_next = S_WRITE;
      end
      S_WRITE: begin
`ifdef IIC_SEQ_VERIFY_EN
        if (w_wr_ok) w_next = r_verify ? S_READ : S_NEXT;
`else
        if (w_wr_ok) w_next = S_NEXT;
`endif
      end
      S_READ: begin
        if (w_rd_ok) w_next = S_NEXT;
      end
      S_NEXT: begin
        w_clr  = 1'b1;
        w_next = (r_last || tbl_idx == IDX_W'(ENTRIES - 1)) ? S_DONE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_retry)   w_next = S_WRITE;
    if (w_give_up) w_next = S_FAIL;
  end

  // Retries re-enter WRITE with wr_req low; it is raised again one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto    <= 1'b1;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_settle  <= '0;
      tbl_idx   <= '0;
      twi_mux   <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      init_done <= 1'b0;
      init_fail <= 1'b0;
      fail_idx  <= '0;
    end else begin
      r_auto <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (w_next == S_FETCH) begin
            tbl_idx   <= '0;
            r_first   <= 1'b1;
            init_done <= 1'b0;
            init_fail <= 1'b0;
            fail_idx  <= '0;
          end
        end
        S_FETCH: begin
          r_first  <= 1'b0;
          r_last   <= w_body.last;
          wr_addr  <= w_body.addr;
          wr_data  <= w_body.val;
          r_settle <= '0;
          if (w_next == S_MUX) twi_mux <= w_ch;
          else                 wr_req  <= 1'b1;
        end
        S_MUX: begin
          if (w_next == S_WRITE) wr_req   <= 1'b1;
          else                   r_settle <= r_settle + SET_W'(1);
        end
        S_WRITE: begin
          if (!wr_req)     wr_req <= 1'b1;
          else if (wr_fin) wr_req <= 1'b0;
        end
        S_NEXT: begin
          if (w_next == S_FETCH) tbl_idx   <= tbl_idx + IDX_W'(1);
          if (w_next == S_DONE)  init_done <= 1'b1;
        end
        default: ;
      endcase
      if (w_give_up) begin
        init_fail <= 1'b1;
        fail_idx  <= tbl_idx;
      end
    end
  end

`ifdef IIC_SEQ_VERIFY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_verify <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= 8'h00;
    end else begin
      if (r_state == S_FETCH) begin
        r_verify <= w_body.verify;
        rd_addr  <= w_body.addr;
      end
      if (r_state == S_WRITE && w_next == S_READ) rd_req <= 1'b1;
      if (r_state == S_READ && rd_req && rd_fin)  rd_req <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Randomized bench for iic_cfg_seq: a scripted I2C responder plus a table-walk reference model.
module tb_iic_cfg_seq;

  localparam int ENTRIES    = 16;
  localparam int CHANNELS   = 4;
  localparam int MAX_RETRY  = 2;
  localparam int MUX_SETTLE = 16;
  localparam int IDX_W      = 4;
  localparam int CH_W       = 2;
  localparam int EW         = CH_W + 18;
  localparam int NSCR       = 128;

  typedef struct {
    int         ch;
    bit         last;
    bit         verify;
    logic [7:0] addr;
    logic [7:0] val;
  } ent_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] ch;
    logic [7:0] addr;
    logic [7:0] data;
  } rec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] tbl_idx;
  logic [EW-1:0]    tbl_entry;
  logic [CH_W-1:0]  twi_mux;
  logic             wr_req, wr_fin, wr_ack;
  logic [7:0]       wr_addr, wr_data;
  logic             rd_req, rd_fin, rd_ack;
  logic [7:0]       rd_addr, rd_data;
  logic             busy, init_done, init_fail;
  logic [IDX_W-1:0] fail_idx;

  ent_t tbl [ENTRIES];
  bit   wack [NSCR];
  bit   rack [NSCR];
  bit   rok  [NSCR];
  bit   resp_clr = 1'b0;
  bit   spur_en  = 1'b0;

  int   n_chk = 0;
  int   n_err = 0;

  rec_t log_q[$];
  rec_t exp_q[$];
  bit   m_done, m_fail;
  int   m_fidx, m_mux;

  always #5 clk = ~clk;

  iic_cfg_seq #(
    .ENTRIES    (ENTRIES),
    .CHANNELS   (CHANNELS),
    .MAX_RETRY  (MAX_RETRY),
    .MUX_SETTLE (MUX_SETTLE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .tbl_idx   (tbl_idx),
    .tbl_entry (tbl_entry),
    .twi_mux   (twi_mux),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_fin    (wr_fin),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_fin    (rd_fin),
    .rd_ack    (rd_ack),
    .busy      (busy),
    .init_done (init_done),
    .init_fail (init_fail),
    .fail_idx  (fail_idx)
  );

  always_comb begin
    tbl_entry = {CH_W'(tbl[tbl_idx].ch), tbl[tbl_idx].last, tbl[tbl_idx].verify,
                 tbl[tbl_idx].addr, tbl[tbl_idx].val};
  end

  // Responder: answers each request after 0..3 idle cycles, taking ack/data from the scripts.
  int wk, rk, w_dly, r_dly, drop_viol = 0;
  bit w_act, r_act, w_pulsed, r_pulsed;
  initial begin
    wr_fin = 1'b0; wr_ack = 1'b0; rd_fin = 1'b0; rd_ack = 1'b0; rd_data = 8'h00;
  end
  always @(negedge clk) begin
    wr_fin = 1'b0;
    rd_fin = 1'b0;
    if (!reset_n || resp_clr) begin
      wk = 0; rk = 0; w_act = 0; r_act = 0; w_pulsed = 0; r_pulsed = 0;
    end else begin
      if (w_pulsed && wr_req) drop_viol++;
      if (r_pulsed && rd_req) drop_viol++;
      w_pulsed = 0;
      r_pulsed = 0;
      if (wr_req) begin
        if (!w_act) begin w_act = 1; w_dly = $urandom_range(0, 3); end
        if (w_dly == 0) begin
          wr_fin = 1'b1; wr_ack = wack[wk % NSCR]; wk++; w_act = 0; w_pulsed = 1;
        end else w_dly--;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        wr_fin = 1'b1; wr_ack = 1'b0;
      end
      if (rd_req) begin
        if (!r_act) begin r_act = 1; r_dly = $urandom_range(0, 3); end
        if (r_dly == 0) begin
          rd_fin  = 1'b1;
          rd_ack  = rack[rk % NSCR];
          rd_data = rok[rk % NSCR] ? tbl[tbl_idx].val : (tbl[tbl_idx].val ^ 8'h01);
          rk++; r_act = 0; r_pulsed = 1;
        end else r_dly--;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        rd_fin = 1'b1; rd_ack = 1'b0; rd_data = 8'h00;
      end
    end
  end

  // Monitor: transaction log, req overlap, fetch-to-request latency, mux settle gap.
  int cyc = 0, ovl = 0, lat_viol = 0, settle_viol = 0;
  int idx_cyc, chg_cyc, lat_exp;
  bit pw, pr, lat_pend, chg_pend;
  logic [IDX_W-1:0] pidx;
  logic [CH_W-1:0]  pmux, idx_mux;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pw = 0; pr = 0; lat_pend = 0; chg_pend = 0; pidx = '0; pmux = '0;
    end else begin
      if (wr_req && rd_req) ovl++;
      if (twi_mux != pmux) begin chg_pend = 1; chg_cyc = cyc; end
      if (tbl_idx != pidx) begin
        lat_pend = (tbl_idx != '0);
        idx_cyc  = cyc;
        idx_mux  = twi_mux;
      end
      if (wr_req && !pw) begin
        log_q.push_back({1'b0, 8'(twi_mux), wr_addr, wr_data});
        if (lat_pend) begin
          lat_exp = (twi_mux != idx_mux) ? MUX_SETTLE + 1 : 1;
          if (cyc - idx_cyc != lat_exp) lat_viol++;
          lat_pend = 0;
        end
        if (chg_pend) begin
          if (cyc - chg_cyc < MUX_SETTLE) settle_viol++;
          chg_pend = 0;
        end
      end
      if (rd_req && !pr) log_q.push_back({1'b1, 8'(twi_mux), rd_addr, 8'h00});
      pw = wr_req; pr = rd_req; pidx = tbl_idx; pmux = twi_mux;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: walk the table entry by entry, consuming scripted responses in issue order.
  task automatic model_run();
    int  w, r, tries;
    bit  pass;
    w = 0; r = 0;
    exp_q.delete();
    m_done = 0; m_fail = 0; m_fidx = 0; m_mux = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      tries = 0;
      m_mux = tbl[i].ch;
      forever begin
        exp_q.push_back({1'b0, 8'(tbl[i].ch), tbl[i].addr, tbl[i].val});
        pass = wack[w]; w++;
`ifdef IIC_SEQ_VERIFY_EN
        if (pass && tbl[i].verify) begin
          exp_q.push_back({1'b1, 8'(tbl[i].ch), tbl[i].addr, 8'h00});
          pass = rack[r] && rok[r]; r++;
        end
`endif
        if (pass) break;
        if (tries == MAX_RETRY) begin m_fail = 1; m_fidx = i; return; end
        tries++;
      end
      if (tbl[i].last || i == ENTRIES - 1) begin m_done = 1; return; end
    end
  endtask

  task automatic fill_scripts(input int nack_pct);
    for (int k = 0; k < NSCR; k++) begin
      wack[k] = ($urandom_range(0, 99) >= nack_pct);
      rack[k] = ($urandom_range(0, 99) >= nack_pct);
      rok[k]  = ($urandom_range(0, 99) >= nack_pct);
    end
  endtask

  task automatic set_entry(input int i, input int ch, input bit last, input bit vfy,
                           input logic [7:0] addr, input logic [7:0] val);
    tbl[i].ch = ch; tbl[i].last = last; tbl[i].verify = vfy; tbl[i].addr = addr; tbl[i].val = val;
  endtask

  task automatic rand_table(input int len);
    int ch;
    ch = $urandom_range(0, CHANNELS - 1);
    for (int i = 0; i < ENTRIES; i++) begin
      if ($urandom_range(0, 9) < 3) ch = $urandom_range(0, CHANNELS - 1);
      set_entry(i, ch, (i == len - 1), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic pulse_start(input bit clr);
    @(posedge clk); #1 start = 1'b1; resp_clr = clr;
    @(posedge clk); #1 start = 1'b0; resp_clr = 1'b0;
  endtask

  task automatic run_seq(input string name, input bit do_start, input int mid_start);
    int base, n;
    model_run();
    base = log_q.size();
    if (do_start) begin
      pulse_start(1'b1);
      @(negedge clk);
      check_eq({name, "_busy_after_start"}, 32'(busy), 32'd1);
      check_eq({name, "_done_cleared"}, 32'(init_done), 32'd0);
      check_eq({name, "_fail_cleared"}, 32'(init_fail), 32'd0);
      check_eq({name, "_fidx_cleared"}, 32'(fail_idx), 32'd0);
    end
    if (mid_start > 0) begin
      repeat (mid_start) @(posedge clk);
      pulse_start(1'b0);
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
    n = log_q.size() - base;
    check_eq({name, "_nxact"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check_eq($sformatf("%s_xact%0d", name, i), 32'(log_q[base + i]), 32'(exp_q[i]));
    check_eq({name, "_init_done"}, 32'(init_done), 32'(m_done));
    check_eq({name, "_init_fail"}, 32'(init_fail), 32'(m_fail));
    check_eq({name, "_fail_idx"}, 32'(fail_idx), 32'(m_fidx));
    check_eq({name, "_twi_mux"}, 32'(twi_mux), 32'(m_mux));
  endtask

  initial begin
    int n;
    for (int i = 0; i < ENTRIES; i++) set_entry(i, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_entry(0, 0, 1'b0, 1'b0, 8'h10, 8'h55);
    set_entry(1, 0, 1'b0, 1'b0, 8'h11, 8'hAA);
    set_entry(2, 0, 1'b1, 1'b0, 8'h12, 8'h01);
    fill_scripts(0);
    repeat (3) @(negedge clk);
    check_eq("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    check_eq("rst_twi_mux", 32'(twi_mux), 32'd0);
    check_eq("rst_fail_idx", 32'(fail_idx), 32'd0);
    check_eq("rst_wr_req", 32'(wr_req), 32'd0);
    check_eq("rst_rd_req", 32'(rd_req), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_init_fail", 32'(init_fail), 32'd0);
    reset_n = 1'b1;
    run_seq("three_wr_autostart", 1'b0, 0);

    set_entry(0, 2, 1'b0, 1'b0, 8'h30, 8'h12);
    set_entry(1, 3, 1'b1, 1'b0, 8'h31, 8'h34);
    run_seq("mux_step", 1'b1, 0);

    set_entry(0, 1, 1'b1, 1'b0, 8'h40, 8'hC3);
    fill_scripts(0);
    wack[0] = 1'b0; wack[1] = 1'b0;
    run_seq("nack_retry", 1'b1, 0);

    set_entry(0, 1, 1'b0, 1'b0, 8'h41, 8'h01);
    set_entry(1, 1, 1'b0, 1'b0, 8'h42, 8'h02);
    set_entry(2, 1, 1'b1, 1'b0, 8'h43, 8'h03);
    fill_scripts(100);
    wack[0] = 1'b1;
    run_seq("nack_fail", 1'b1, 0);

`ifdef IIC_SEQ_VERIFY_EN
    set_entry(0, 0, 1'b1, 1'b1, 8'h20, 8'h7F);
    fill_scripts(0);
    for (int k = 0; k < NSCR; k++) rok[k] = 1'b0;
    run_seq("verify_fail", 1'b1, 0);
`endif

    fill_scripts(0);
    set_entry(0, 1, 1'b0, 1'b0, 8'h50, 8'h11);
    set_entry(1, 2, 1'b0, 1'b0, 8'h51, 8'h22);
    set_entry(2, 2, 1'b1, 1'b0, 8'h52, 8'h33);
    run_seq("restart_after_fail", 1'b1, 0);
    run_seq("start_while_busy", 1'b1, 20);

    pulse_start(1'b1);
    n = 0;
    @(negedge clk);
    while (!wr_req && n < 200) begin @(negedge clk); n++; end
    check_eq("midrst_wr_seen", 32'(wr_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_wr_req", 32'(wr_req), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_tbl_idx", 32'(tbl_idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_seq("midrst_autostart", 1'b0, 0);

    spur_en = 1'b1;
    for (int t = 0; t < 14; t++) begin
      rand_table((t % 4 == 3) ? ENTRIES + 1 : $urandom_range(1, ENTRIES));
      fill_scripts((t % 5 == 4) ? 60 : 15);
      run_seq($sformatf("rand%0d", t), 1'b1, 0);
    end

    check_eq("req_overlap", 32'(ovl), 32'd0);
    check_eq("req_drop_after_fin", 32'(drop_viol), 32'd0);
    check_eq("fetch_to_wr_req_latency", 32'(lat_viol), 32'd0);
    check_eq("mux_settle_gap", 32'(settle_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
